// File: rtl/my_timer_multi_if.sv
// Avalon-MM slave bus for the multi-channel timer: 16-bit data, 1-cycle read latency.
interface my_timer_multi_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/my_timer_multi.sv
// Multi-channel interval timer: per-channel prescaled down-counter, one-shot or
// continuous, snapshot register and timeout IRQ, OR-combined onto irq.
module my_timer_multi #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned COUNT_W      = 32,
    parameter int unsigned PRESCALE_W   = 16,
    parameter logic [31:0] RESET_PERIOD = 32'h017D783F
) (
    input  logic                clk,
    input  logic                reset_n,
    my_timer_multi_if.slave     bus,
    output logic                irq,
    output logic [CHANNELS-1:0] ch_irq
);
    localparam int unsigned ADDR_W = 3 + $clog2(CHANNELS);
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [COUNT_W-1:0] RST_PERIOD = COUNT_W'(RESET_PERIOD);

    logic [COUNT_W-1:0]    period_q   [CHANNELS];
    logic [COUNT_W-1:0]    period_d   [CHANNELS];
    logic [COUNT_W-1:0]    counter_q  [CHANNELS];
    logic [COUNT_W-1:0]    counter_d  [CHANNELS];
    logic [COUNT_W-1:0]    snap_q     [CHANNELS];
    logic [COUNT_W-1:0]    snap_d     [CHANNELS];
    logic [PRESCALE_W-1:0] prescale_q [CHANNELS];
    logic [PRESCALE_W-1:0] prescale_d [CHANNELS];
    logic [PRESCALE_W-1:0] pcnt_q     [CHANNELS];
    logic [PRESCALE_W-1:0] pcnt_d     [CHANNELS];
    logic [CHANNELS-1:0]   run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic [CHANNELS-1:0]   reload_q, reload_d, ch_irq_d;
    logic [CHANNELS-1:0]   sel, tick, tmo, start, wr_period;
    logic [CH_W-1:0]       ch_idx;
    logic [2:0]            reg_idx;
    logic                  wr_en;
    logic [15:0]           rdata_d, rdata_q;
    logic                  irq_q;

    // Channel field of the word address; a single channel has no channel bits.
    if (CHANNELS > 1) begin : g_ch_idx
        assign ch_idx = bus.address[ADDR_W-1:3];
    end else begin : g_ch_one
        assign ch_idx = '0;
    end

    assign reg_idx      = bus.address[2:0];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

    // Per-channel next state: register writes, prescaler, counter and flags.
    always_comb begin
        sel       = '0;
        tick      = '0;
        tmo       = '0;
        start     = '0;
        wr_period = '0;
        run_d     = run_q;
        to_d      = to_q;
        ito_d     = ito_q;
        cont_d    = cont_q;
        reload_d  = '0;
        ch_irq_d  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            period_d[c]   = period_q[c];
            counter_d[c]  = counter_q[c];
            snap_d[c]     = snap_q[c];
            prescale_d[c] = prescale_q[c];
            pcnt_d[c]     = pcnt_q[c];

            sel[c]       = wr_en && (ch_idx == CH_W'(c));
            start[c]     = sel[c] && (reg_idx == 3'd1) && bus.writedata[2];
            wr_period[c] = sel[c] && ((reg_idx == 3'd2) || (reg_idx == 3'd3));
            tick[c]      = run_q[c] && (pcnt_q[c] == prescale_q[c]);
            tmo[c]       = tick[c] && (counter_q[c] == '0);

            // Prescaler restarts on any event that redefines the timebase.
            if (!run_q[c] || start[c] || wr_period[c] ||
                (sel[c] && (reg_idx == 3'd6)) || tick[c])
                pcnt_d[c] = '0;
            else
                pcnt_d[c] = pcnt_q[c] + PRESCALE_W'(1);

            // A period write reloads the counter one clock after it lands.
            if (reload_q[c])
                counter_d[c] = period_q[c];
            else if (tmo[c])
                counter_d[c] = period_q[c];
            else if (tick[c])
                counter_d[c] = counter_q[c] - COUNT_W'(1);

            if (tmo[c])
                run_d[c] = cont_q[c];

            if (sel[c]) begin
                unique case (reg_idx)
                    3'd0: to_d[c] = 1'b0;
                    3'd1: begin
                        ito_d[c]  = bus.writedata[0];
                        cont_d[c] = bus.writedata[1];
                        if (bus.writedata[2])
                            run_d[c] = 1'b1;
                        else if (bus.writedata[3])
                            run_d[c] = 1'b0;
                    end
                    3'd2: period_d[c][15:0] = bus.writedata;
                    3'd3: period_d[c][COUNT_W-1:16] = bus.writedata[COUNT_W-17:0];
                    3'd4, 3'd5: snap_d[c] = counter_q[c];
                    3'd6: prescale_d[c] = bus.writedata[PRESCALE_W-1:0];
                    default: ;
                endcase
            end

            if (wr_period[c]) begin
                run_d[c]    = 1'b0;
                reload_d[c] = 1'b1;
            end

            // A timeout on the same clock as a STATUS clear keeps TO set.
            if (tmo[c])
                to_d[c] = 1'b1;

            ch_irq_d[c] = to_d[c] & ito_d[c];
        end
    end

    // Read mux; registered every clock regardless of chipselect.
    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == CH_W'(c)) begin
                unique case (reg_idx)
                    3'd0:    rdata_d = {14'd0, run_q[c], to_q[c]};
                    3'd1:    rdata_d = {14'd0, cont_q[c], ito_q[c]};
                    3'd2:    rdata_d = period_q[c][15:0];
                    3'd3:    rdata_d = 16'(period_q[c] >> 16);
                    3'd4:    rdata_d = snap_q[c][15:0];
                    3'd5:    rdata_d = 16'(snap_q[c] >> 16);
                    3'd6:    rdata_d = 16'(prescale_q[c]);
                    default: rdata_d = '0;
                endcase
            end
        end
    end

    // State registers, read data and interrupt outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                period_q[c]   <= RST_PERIOD;
                counter_q[c]  <= RST_PERIOD;
                snap_q[c]     <= '0;
                prescale_q[c] <= '0;
                pcnt_q[c]     <= '0;
            end
            run_q    <= '0;
            to_q     <= '0;
            ito_q    <= '0;
            cont_q   <= '0;
            reload_q <= '0;
            ch_irq   <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                period_q[c]   <= period_d[c];
                counter_q[c]  <= counter_d[c];
                snap_q[c]     <= snap_d[c];
                prescale_q[c] <= prescale_d[c];
                pcnt_q[c]     <= pcnt_d[c];
            end
            run_q    <= run_d;
            to_q     <= to_d;
            ito_q    <= ito_d;
            cont_q   <= cont_d;
            reload_q <= reload_d;
            ch_irq   <= ch_irq_d;
            irq_q    <= |ch_irq_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_my_timer_multi.sv
// Directed bench for my_timer_multi with three channels (channel 3 unmapped).
module tb_my_timer_multi;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned ADDR_W   = 5;

    logic                clk;
    logic                reset_n;
    logic                irq;
    logic [CHANNELS-1:0] ch_irq;
    logic [15:0]         v;
    int                  vectors;
    int                  miscompares;

    my_timer_multi_if #(.ADDR_W(ADDR_W)) bus ();

    my_timer_multi #(
        .CHANNELS     (CHANNELS),
        .COUNT_W      (32),
        .PRESCALE_W   (16),
        .RESET_PERIOD (32'h017D783F)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq     (irq),
        .ch_irq  (ch_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [1:0] ch, input logic [2:0] r, input logic [15:0] d);
        bus.address    = {ch, r};
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Called at a falling edge; returns data registered on the next rising edge.
    task automatic rd(input logic [1:0] ch, input logic [2:0] r, output logic [15:0] d);
        bus.address    = {ch, r};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        d              = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (2) @(negedge clk);
        chk("rst_readdata", bus.readdata, 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_ch_irq", 16'(ch_irq), 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 2, v); chk("rst_period_l", v, 16'h783F);
        rd(0, 3, v); chk("rst_period_h", v, 16'h017D);

        // T1: ch0 period 9, prescale 0, continuous with ITO
        wr(0, 3, 16'h0000);
        wr(0, 2, 16'h0009);
        wr(0, 1, 16'h0007);
        repeat (9) @(negedge clk);
        chk("t1_before_to", 16'(ch_irq), 16'h0000);
        @(negedge clk);
        chk("t1_ch_irq", 16'(ch_irq), 16'h0001);
        chk("t1_irq", 16'(irq), 16'h0001);
        rd(0, 0, v); chk("t1_status", v, 16'h0003);

        // T3: clear TO, then STATUS write on the exact timeout clock
        wr(0, 0, 16'h0000);
        chk("t3_cleared", 16'(ch_irq), 16'h0000);
        repeat (7) @(negedge clk);
        wr(0, 0, 16'h0000);
        chk("t3_set_wins", 16'(ch_irq), 16'h0001);
        wr(0, 0, 16'h0000);
        chk("t3_clear_ch", 16'(ch_irq), 16'h0000);
        chk("t3_clear_irq", 16'(irq), 16'h0000);

        // T4: period 0x00012345 running, snapshot, then PERIOD_H write mid-run
        wr(0, 3, 16'h0001);
        wr(0, 2, 16'h2345);
        wr(0, 1, 16'h0006);
        @(negedge clk);
        wr(0, 4, 16'h0000);
        rd(0, 4, v); chk("t4_snap_l", v, 16'h2344);
        rd(0, 5, v); chk("t4_snap_h", v, 16'h0001);
        wr(0, 3, 16'h0000);
        rd(0, 0, v); chk("t4_stopped", v, 16'h0000);
        wr(0, 5, 16'h0000);
        rd(0, 4, v); chk("t4_reload_l", v, 16'h2345);
        rd(0, 5, v); chk("t4_reload_h", v, 16'h0000);

        // T2: ch1 period 4, prescale 3, one-shot with ITO
        wr(1, 3, 16'h0000);
        wr(1, 2, 16'h0004);
        wr(1, 6, 16'h0003);
        wr(1, 1, 16'h0005);
        repeat (19) @(negedge clk);
        chk("t2_before_to", 16'(ch_irq), 16'h0000);
        @(negedge clk);
        chk("t2_ch_irq", 16'(ch_irq), 16'h0002);
        chk("t2_irq", 16'(irq), 16'h0001);
        rd(1, 0, v); chk("t2_status", v, 16'h0001);
        wr(1, 4, 16'h0000);
        rd(1, 4, v); chk("t2_reloaded", v, 16'h0004);
        rd(1, 6, v); chk("t2_prescale", v, 16'h0003);

        // T5: both channels with ITO and different periods
        chk("t5_ch1_only", 16'(ch_irq), 16'h0002);
        wr(0, 2, 16'h0002);
        wr(0, 1, 16'h0005);
        wr(1, 0, 16'h0000);
        chk("t5_none", 16'(ch_irq), 16'h0000);
        chk("t5_irq_low", 16'(irq), 16'h0000);
        @(negedge clk);
        chk("t5_none_b", 16'(ch_irq), 16'h0000);
        @(negedge clk);
        chk("t5_ch0", 16'(ch_irq), 16'h0001);
        chk("t5_irq_ch0", 16'(irq), 16'h0001);
        wr(1, 1, 16'h0005);
        repeat (19) @(negedge clk);
        chk("t5_ch0_only", 16'(ch_irq), 16'h0001);
        @(negedge clk);
        chk("t5_both", 16'(ch_irq), 16'h0003);
        chk("t5_irq_both", 16'(irq), 16'h0001);
        wr(3, 2, 16'h1111);
        rd(3, 2, v); chk("t5_unmapped_per", v, 16'h0000);
        rd(3, 0, v); chk("t5_unmapped_st", v, 16'h0000);
        rd(0, 7, v); chk("t5_reserved", v, 16'h0000);
        rd(2, 2, v); chk("t5_ch2_untouched", v, 16'h783F);

        // T6: reset asserted mid-count
        wr(0, 1, 16'h0007);
        repeat (3) @(negedge clk);
        chk("t6_pre_ch_irq", 16'(ch_irq), 16'h0003);
        chk("t6_pre_readdata", bus.readdata, 16'h0003);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_irq", 16'(irq), 16'h0000);
        chk("t6_ch_irq", 16'(ch_irq), 16'h0000);
        chk("t6_readdata", bus.readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 2, v); chk("t6_period_l", v, 16'h783F);
        rd(0, 3, v); chk("t6_period_h", v, 16'h017D);
        rd(0, 0, v); chk("t6_status", v, 16'h0000);
        rd(1, 6, v); chk("t6_prescale", v, 16'h0000);
        rd(1, 1, v); chk("t6_control", v, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
